csi2_pkt_hdr_parse: RTL and testbench
=====================================

Name: csi2_pkt_hdr_parse

Overview:
- Upstream neighbour of the CSI-2 frame assembly stage.
- Takes lane-merged, word-aligned 32-bit CSI-2 byte stream; decodes and ECC-checks the 4-byte packet header.
- Emits the header strobe, data type and a payload word stream with CRC stripped; generates the frame-level vsync level from FS/FE short packets.
- Errored and unwanted packets are dropped here so downstream sees only clean packets.

Parameters:
- VC_EN, 0: 1 = accept only packets whose virtual channel equals VC_SEL; 0 = accept all VCs.
- VC_SEL, 2'd0: virtual channel accepted when VC_EN=1.
- PASS_SHORT, 0: 1 = pulse ecc_end for every short packet; 0 = only for FS (0x00) and FE (0x01).

Ports:
- pixel_clk  in  1  single clock; everything is synchronous to its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- lane_dat  in  32  merged lane bytes; byte0=[7:0] is first on the wire.
- lane_vld  in  1  lane_dat valid this cycle.
- lane_sot  in  1  with lane_vld, marks the header word: DI=[7:0], WC=[23:8], ECC=[31:24].
- ecc_end  out  1  one-cycle pulse: accepted header.
- dat_type  out  6  DI[5:0] of last accepted header, held.
- vc  out  2  DI[7:6] of last accepted header, held.
- word_cnt  out  16  WC of last accepted header, held.
- dat_vld  out  1  payload word valid.
- dat_32bit  out  32  payload word; bytes beyond WC zeroed.
- rx_vsync_pls  out  1  high from accepted FS to accepted FE.
- ecc_err  out  1  one-cycle pulse: header syndrome nonzero.
- trunc_err  out  1  one-cycle pulse: new lane_sot before previous packet fully consumed.
- err_cnt  out  8  saturating count of ecc_err + trunc_err events.

Behaviour:
- Reset values: all outputs 0. State is IDLE and the byte counter is 0.
- ECC: CSI-2 modified Hamming code over 24 header bits. 6 parity bits; ECC[7:6] expected 0. Syndrome = received ECC XOR computed ECC (8 bits).
- Syndrome is computed combinationally on the header word and registered. No correction is performed: any nonzero syndrome is an error.
- States:
  - IDLE: wait for lane_vld & lane_sot. lane_vld words without sot are ignored.
  - HDR (the sot cycle, evaluated same edge):
    - Syndrome != 0 -> ecc_err at N+1, go to IDLE. No ecc_end, no dat_* updates.
    - VC filter rejects -> DROP, or IDLE if short packet.
    - Short packet (DT < 0x10) -> IDLE.
    - Long packet -> PAYLOAD with bytes_left = WC, crc_left = 2.
  - PAYLOAD: each lane_vld word consumes min(4, bytes_left) payload bytes, then CRC bytes.
    - dat_vld=1 at the next cycle for any word carrying at least 1 payload byte.
    - A word that mixes last payload bytes and CRC bytes is output with the CRC byte lanes zeroed.
    - When payload and CRC bytes are all consumed -> IDLE.
    - lane_vld=0 stalls: counters held, dat_vld=0.
  - DROP: same byte accounting as PAYLOAD, dat_vld forced 0. Go to IDLE when done.
- Latency: header word at cycle N -> ecc_end, dat_type, vc, word_cnt updated at N+1. Payload word at cycle M -> dat_vld/dat_32bit at M+1.
- ecc_end is suppressed for short packets other than 0x00/0x01 unless PASS_SHORT=1. dat_type/vc/word_cnt update on every accepted header.
- rx_vsync_pls:
  - Set at N+1 of an accepted FS; cleared at N+1 of an accepted FE.
  - A second FS while high: stays high.
  - FE while low: stays low.
- WC=0 long packet: no dat_vld; only the 2 CRC bytes are consumed.
- Truncation: lane_sot (with lane_vld) in PAYLOAD/DROP aborts the current packet, pulses trunc_err at next cycle, and the word is processed as a fresh header in the same cycle.
- err_cnt saturates at 255. If ecc_err and trunc_err fire on the same cycle, err_cnt increments by 2 (saturating).
- Reset mid-packet: immediate return to IDLE; rx_vsync_pls cleared.

Test Plan:
- FS header (DT 0x00, WC 0x0001, bench-computed ECC) -> ecc_end 1 cycle, dat_type=0, rx_vsync_pls rises at N+1; then FE -> rx_vsync_pls falls.
- Long RAW10 packet DT 0x2B, WC=10, payload bytes 0x01..0x0A + 2 CRC -> three dat_vld words: 0x04030201, 0x08070605, 0x00000A09; then IDLE.
- Same packet with lane_vld gaps of 3 cycles between words -> identical output words, dat_vld only on valid cycles.
- Header with one flipped WC bit -> ecc_err pulse, no ecc_end, no dat_vld, err_cnt=1, dat_type unchanged.
- VC_EN=1, VC_SEL=1; long packet on VC0 then VC1 -> only VC1 produces ecc_end/dat_vld. Line-start DT 0x02 with PASS_SHORT=0 -> no ecc_end.
- lane_sot arriving after 2 of 5 payload words -> trunc_err pulse, new header accepted with ecc_end at next cycle. Also: 300 errors -> err_cnt holds 255.

Source files
------------

// File: rtl/csi2_pkt_hdr_parse.sv
// CSI-2 packet header parser.
// Decodes and ECC-checks the 4-byte packet header of a word-aligned, lane-merged
// CSI-2 byte stream, strips the trailing CRC from long packets and forwards only
// clean, wanted packets. FS/FE short packets drive a frame-level vsync level.
//
// Ports:
//   pixel_clk    in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   lane_dat     in   [31:0] merged lane bytes, byte0 = [7:0] first on the wire
//   lane_vld     in   lane_dat valid
//   lane_sot     in   with lane_vld marks a header word: DI=[7:0] WC=[23:8] ECC=[31:24]
//   ecc_end      out  one-cycle pulse per accepted (and reportable) header
//   dat_type     out  [5:0]  DI[5:0] of last accepted header
//   vc           out  [1:0]  DI[7:6] of last accepted header
//   word_cnt     out  [15:0] WC of last accepted header
//   dat_vld      out  payload word valid
//   dat_32bit    out  [31:0] payload word, non-payload byte lanes zeroed
//   rx_vsync_pls out  high from accepted FS to accepted FE
//   ecc_err      out  one-cycle pulse on nonzero header syndrome
//   trunc_err    out  one-cycle pulse when a header cuts short the previous packet
//   err_cnt      out  [7:0] saturating count of ecc_err + trunc_err events
module csi2_pkt_hdr_parse #(
    parameter bit         VC_EN      = 1'b0,
    parameter logic [1:0] VC_SEL     = 2'd0,
    parameter bit         PASS_SHORT = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic [31:0] lane_dat,
    input  logic        lane_vld,
    input  logic        lane_sot,
    output logic        ecc_end,
    output logic [5:0]  dat_type,
    output logic [1:0]  vc,
    output logic [15:0] word_cnt,
    output logic        dat_vld,
    output logic [31:0] dat_32bit,
    output logic        rx_vsync_pls,
    output logic        ecc_err,
    output logic        trunc_err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {StIdle, StPayload, StDrop} state_e;

    state_e      state_q;
    logic [15:0] bytes_left_q;
    logic [1:0]  crc_left_q;

    // Header decode and ECC (CSI-2 modified Hamming, ECC[7:6] must be zero)
    logic [23:0] hdr;
    logic [5:0]  ecc_calc;
    logic [7:0]  syndrome;
    logic        sot_hit;
    logic        hdr_bad;
    logic        hdr_trunc;
    logic        hdr_long;
    logic        hdr_fsfe;
    logic        vc_ok;

    assign hdr = lane_dat[23:0];

    assign ecc_calc[0] = hdr[0] ^ hdr[1] ^ hdr[2] ^ hdr[4] ^ hdr[5] ^ hdr[7] ^ hdr[10] ^
                         hdr[11] ^ hdr[13] ^ hdr[16] ^ hdr[20] ^ hdr[21] ^ hdr[22] ^ hdr[23];
    assign ecc_calc[1] = hdr[0] ^ hdr[1] ^ hdr[3] ^ hdr[4] ^ hdr[6] ^ hdr[8] ^ hdr[10] ^
                         hdr[12] ^ hdr[14] ^ hdr[17] ^ hdr[20] ^ hdr[21] ^ hdr[22] ^ hdr[23];
    assign ecc_calc[2] = hdr[0] ^ hdr[2] ^ hdr[3] ^ hdr[5] ^ hdr[6] ^ hdr[9] ^ hdr[11] ^
                         hdr[12] ^ hdr[15] ^ hdr[18] ^ hdr[20] ^ hdr[21] ^ hdr[22];
    assign ecc_calc[3] = hdr[1] ^ hdr[2] ^ hdr[3] ^ hdr[7] ^ hdr[8] ^ hdr[9] ^ hdr[13] ^
                         hdr[14] ^ hdr[15] ^ hdr[19] ^ hdr[20] ^ hdr[21] ^ hdr[23];
    assign ecc_calc[4] = hdr[4] ^ hdr[5] ^ hdr[6] ^ hdr[7] ^ hdr[8] ^ hdr[9] ^ hdr[16] ^
                         hdr[17] ^ hdr[18] ^ hdr[19] ^ hdr[20] ^ hdr[22] ^ hdr[23];
    assign ecc_calc[5] = hdr[10] ^ hdr[11] ^ hdr[12] ^ hdr[13] ^ hdr[14] ^ hdr[15] ^
                         hdr[16] ^ hdr[17] ^ hdr[18] ^ hdr[19] ^ hdr[21] ^ hdr[22] ^ hdr[23];

    assign syndrome  = lane_dat[31:24] ^ {2'b00, ecc_calc};
    assign sot_hit   = lane_vld & lane_sot;
    assign hdr_bad   = sot_hit & (syndrome != 8'h00);
    assign hdr_trunc = sot_hit & (state_q != StIdle);
    assign hdr_long  = (lane_dat[5:0] >= 6'h10);
    assign hdr_fsfe  = (lane_dat[5:1] == 5'd0);
    assign vc_ok     = !VC_EN || (lane_dat[7:6] == VC_SEL);

    // Byte accounting for one body word: payload bytes first, then CRC bytes
    logic [2:0]  pay_bytes;
    logic [2:0]  crc_room;
    logic [1:0]  crc_next;
    logic [15:0] bytes_next;
    logic        word_done;
    logic [31:0] masked;
    logic [8:0]  err_sum;

    assign pay_bytes  = (bytes_left_q >= 16'd4) ? 3'd4 : bytes_left_q[2:0];
    assign crc_room   = 3'd4 - pay_bytes;
    assign crc_next   = (crc_room >= {1'b0, crc_left_q}) ? 2'd0 : crc_left_q - crc_room[1:0];
    assign bytes_next = bytes_left_q - {13'd0, pay_bytes};
    assign word_done  = ({1'b0, bytes_left_q} + {15'd0, crc_left_q}) <= 17'd4;
    assign err_sum    = {1'b0, err_cnt} + {8'd0, hdr_bad} + {8'd0, hdr_trunc};

    always_comb begin
        masked = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < pay_bytes) masked[8*i +: 8] = lane_dat[8*i +: 8];
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            bytes_left_q <= 16'd0;
            crc_left_q   <= 2'd0;
            ecc_end      <= 1'b0;
            dat_type     <= 6'd0;
            vc           <= 2'd0;
            word_cnt     <= 16'd0;
            dat_vld      <= 1'b0;
            dat_32bit    <= 32'd0;
            rx_vsync_pls <= 1'b0;
            ecc_err      <= 1'b0;
            trunc_err    <= 1'b0;
            err_cnt      <= 8'd0;
        end else begin
            ecc_end   <= 1'b0;
            dat_vld   <= 1'b0;
            ecc_err   <= hdr_bad;
            trunc_err <= hdr_trunc;
            err_cnt   <= err_sum[8] ? 8'hFF : err_sum[7:0];

            if (sot_hit) begin
                // A header always restarts parsing, aborting any packet in flight
                bytes_left_q <= lane_dat[23:8];
                crc_left_q   <= 2'd2;
                if (hdr_bad) begin
                    state_q <= StIdle;
                end else if (!vc_ok) begin
                    state_q <= hdr_long ? StDrop : StIdle;
                end else begin
                    state_q  <= hdr_long ? StPayload : StIdle;
                    dat_type <= lane_dat[5:0];
                    vc       <= lane_dat[7:6];
                    word_cnt <= lane_dat[23:8];
                    ecc_end  <= hdr_long || hdr_fsfe || PASS_SHORT;
                    if (lane_dat[5:0] == 6'h00) rx_vsync_pls <= 1'b1;
                    if (lane_dat[5:0] == 6'h01) rx_vsync_pls <= 1'b0;
                end
            end else if (lane_vld && state_q != StIdle) begin
                if (state_q == StPayload && pay_bytes != 3'd0) begin
                    dat_vld   <= 1'b1;
                    dat_32bit <= masked;
                end
                bytes_left_q <= bytes_next;
                crc_left_q   <= crc_next;
                if (word_done) state_q <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_csi2_pkt_hdr_parse.sv
// Bench for csi2_pkt_hdr_parse: two instances (default parameters, and VC filter on
// VC1 with PASS_SHORT) share one random/directed stimulus stream; each is compared
// every cycle against a packet-position reference model.
module tb_csi2_pkt_hdr_parse;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic [31:0] lane_dat  = 32'd0;
    logic        lane_vld  = 1'b0;
    logic        lane_sot  = 1'b0;

    logic        ecc_end_w   [2];
    logic [5:0]  dat_type_w  [2];
    logic [1:0]  vc_w        [2];
    logic [15:0] word_cnt_w  [2];
    logic        dat_vld_w   [2];
    logic [31:0] dat_32bit_w [2];
    logic        vsync_w     [2];
    logic        ecc_err_w   [2];
    logic        trunc_err_w [2];
    logic [7:0]  err_cnt_w   [2];

    always #5 pixel_clk = ~pixel_clk;

    csi2_pkt_hdr_parse u_dut0 (
        .pixel_clk    (pixel_clk),
        .reset_n      (reset_n),
        .lane_dat     (lane_dat),
        .lane_vld     (lane_vld),
        .lane_sot     (lane_sot),
        .ecc_end      (ecc_end_w[0]),
        .dat_type     (dat_type_w[0]),
        .vc           (vc_w[0]),
        .word_cnt     (word_cnt_w[0]),
        .dat_vld      (dat_vld_w[0]),
        .dat_32bit    (dat_32bit_w[0]),
        .rx_vsync_pls (vsync_w[0]),
        .ecc_err      (ecc_err_w[0]),
        .trunc_err    (trunc_err_w[0]),
        .err_cnt      (err_cnt_w[0])
    );

    csi2_pkt_hdr_parse #(
        .VC_EN      (1'b1),
        .VC_SEL     (2'd1),
        .PASS_SHORT (1'b1)
    ) u_dut1 (
        .pixel_clk    (pixel_clk),
        .reset_n      (reset_n),
        .lane_dat     (lane_dat),
        .lane_vld     (lane_vld),
        .lane_sot     (lane_sot),
        .ecc_end      (ecc_end_w[1]),
        .dat_type     (dat_type_w[1]),
        .vc           (vc_w[1]),
        .word_cnt     (word_cnt_w[1]),
        .dat_vld      (dat_vld_w[1]),
        .dat_32bit    (dat_32bit_w[1]),
        .rx_vsync_pls (vsync_w[1]),
        .ecc_err      (ecc_err_w[1]),
        .trunc_err    (trunc_err_w[1]),
        .err_cnt      (err_cnt_w[1])
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Parity-bit membership of each of the 24 header bits
    function automatic logic [5:0] ecc_col(input int i);
        case (i)
            0: return 6'h07;   1: return 6'h0B;   2: return 6'h0D;   3: return 6'h0E;
            4: return 6'h13;   5: return 6'h15;   6: return 6'h16;   7: return 6'h19;
            8: return 6'h1A;   9: return 6'h1C;  10: return 6'h23;  11: return 6'h25;
           12: return 6'h26;  13: return 6'h29;  14: return 6'h2A;  15: return 6'h2C;
           16: return 6'h31;  17: return 6'h32;  18: return 6'h34;  19: return 6'h38;
           20: return 6'h1F;  21: return 6'h2F;  22: return 6'h37;  default: return 6'h3B;
        endcase
    endfunction

    function automatic logic [7:0] ecc_of(input logic [23:0] d);
        logic [7:0] e = 8'h00;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= {2'b00, ecc_col(i)};
        return e;
    endfunction

    // Reference model: per instance, position within the current packet body
    bit         vc_en_p  [2] = '{1'b0, 1'b1};
    logic [1:0] vc_sel_p [2] = '{2'd0, 2'd1};
    bit         pass_p   [2] = '{1'b0, 1'b1};

    int          m_act [2];  // 0 none, 1 forwarding, 2 dropping
    int          m_pos [2];
    int          m_wc  [2];
    int          m_ecnt[2];
    logic        x_end [2], x_vld [2], x_eerr [2], x_terr [2], x_vs [2];
    logic [31:0] x_dat [2];
    logic [5:0]  x_dt  [2];
    logic [1:0]  x_vc  [2];
    logic [15:0] x_wc  [2];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_act[p] = 0; m_pos[p] = 0; m_wc[p] = 0; m_ecnt[p] = 0;
            x_end[p] = 0; x_vld[p] = 0; x_eerr[p] = 0; x_terr[p] = 0; x_vs[p] = 0;
            x_dat[p] = 0; x_dt[p] = 0; x_vc[p] = 0; x_wc[p] = 0;
        end
    endtask

    task automatic model_step(input int p, input logic v, input logic s, input logic [31:0] d);
        x_end[p] = 0; x_vld[p] = 0; x_eerr[p] = 0; x_terr[p] = 0;
        if (v && s) begin
            bit bad;
            bit tr;
            bad = (ecc_of(d[23:0]) != d[31:24]);
            tr  = (m_act[p] != 0);
            x_eerr[p] = bad;
            x_terr[p] = tr;
            m_ecnt[p] = m_ecnt[p] + int'(bad) + int'(tr);
            if (m_ecnt[p] > 255) m_ecnt[p] = 255;
            m_act[p] = 0;
            if (!bad) begin
                int  dt;
                bit  ok;
                bit  is_long;
                dt      = int'(d[5:0]);
                ok      = !vc_en_p[p] || (d[7:6] == vc_sel_p[p]);
                is_long = (dt >= 16);
                if (ok) begin
                    x_dt[p]  = d[5:0];
                    x_vc[p]  = d[7:6];
                    x_wc[p]  = d[23:8];
                    x_end[p] = is_long || dt == 0 || dt == 1 || pass_p[p];
                    if (dt == 0) x_vs[p] = 1;
                    if (dt == 1) x_vs[p] = 0;
                end
                if (is_long) begin
                    m_act[p] = ok ? 1 : 2;
                    m_pos[p] = 0;
                    m_wc[p]  = int'(d[23:8]);
                end
            end
        end else if (v && m_act[p] != 0) begin
            int          nb;
            logic [31:0] w;
            nb = 0;
            w  = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (m_pos[p] + k < m_wc[p]) begin
                    w[8*k +: 8] = d[8*k +: 8];
                    nb++;
                end
            end
            if (m_act[p] == 1 && nb > 0) begin
                x_vld[p] = 1;
                x_dat[p] = w;
            end
            m_pos[p] += 4;
            if (m_pos[p] >= m_wc[p] + 2) m_act[p] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < 2; p++) begin
            check($sformatf("u%0d.ecc_end", p),   32'(ecc_end_w[p]),   32'(x_end[p]));
            check($sformatf("u%0d.dat_vld", p),   32'(dat_vld_w[p]),   32'(x_vld[p]));
            check($sformatf("u%0d.ecc_err", p),   32'(ecc_err_w[p]),   32'(x_eerr[p]));
            check($sformatf("u%0d.trunc_err", p), 32'(trunc_err_w[p]), 32'(x_terr[p]));
            check($sformatf("u%0d.vsync", p),     32'(vsync_w[p]),     32'(x_vs[p]));
            check($sformatf("u%0d.dat_type", p),  32'(dat_type_w[p]),  32'(x_dt[p]));
            check($sformatf("u%0d.vc", p),        32'(vc_w[p]),        32'(x_vc[p]));
            check($sformatf("u%0d.word_cnt", p),  32'(word_cnt_w[p]),  32'(x_wc[p]));
            check($sformatf("u%0d.err_cnt", p),   32'(err_cnt_w[p]),   32'(m_ecnt[p]));
            if (x_vld[p]) check($sformatf("u%0d.dat_32bit", p), dat_32bit_w[p], x_dat[p]);
        end
    endtask

    // One clock: check the outputs produced by the previous inputs, then drive new ones
    task automatic cycle(input logic v, input logic s, input logic [31:0] d);
        @(negedge pixel_clk);
        check_outputs();
        lane_vld = v;
        lane_sot = s;
        lane_dat = d;
        if (reset_n) for (int p = 0; p < 2; p++) model_step(p, v, s, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'($urandom), $urandom);
    endtask

    // Header, then body words (payload + 2 CRC bytes), with random idle gaps.
    // flip >= 0 corrupts that header bit; cut >= 0 sends only that many body words.
    task automatic send_pkt(input logic [5:0] dt, input logic [1:0] vcid, input logic [15:0] wc,
                            input int flip, input int gmin, input int gmax, input int cut,
                            input bit pat);
        logic [23:0] h;
        logic [31:0] hw;
        int          nw;
        h  = {wc, vcid, dt};
        hw = {ecc_of(h), h};
        if (flip >= 0) hw[flip] = ~hw[flip];
        cycle(1'b1, 1'b1, hw);
        if (dt >= 6'h10) begin
            nw = (int'(wc) + 2 + 3) / 4;
            if (cut >= 0 && cut < nw) nw = cut;
            for (int w = 0; w < nw; w++) begin
                logic [31:0] word;
                idle($urandom_range(gmax, gmin));
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = w * 4 + k;
                    word[8*k +: 8] = (pat && idx < int'(wc)) ? 8'(idx + 1) : 8'($urandom);
                end
                cycle(1'b1, 1'b0, word);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        check_outputs();
        reset_n  = 1'b0;
        lane_vld = 1'b0;
        lane_sot = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge pixel_clk);
        check_outputs();
        reset_n = 1'b1;
    endtask

    logic [5:0] dt_pick [6] = '{6'h00, 6'h01, 6'h02, 6'h2B, 6'h1E, 6'h12};

    initial begin
        model_reset();
        idle(2);
        @(negedge pixel_clk);
        check_outputs();
        reset_n = 1'b1;
        idle(2);

        // FS then FE on VC0 and VC1
        send_pkt(6'h00, 2'd0, 16'h0001, -1, 0, 0, -1, 1'b0);
        idle(2);
        send_pkt(6'h01, 2'd0, 16'h0001, -1, 0, 0, -1, 1'b0);
        send_pkt(6'h00, 2'd1, 16'h0001, -1, 0, 0, -1, 1'b0);
        send_pkt(6'h00, 2'd1, 16'h0002, -1, 0, 0, -1, 1'b0);
        send_pkt(6'h01, 2'd1, 16'h0001, -1, 0, 0, -1, 1'b0);
        send_pkt(6'h01, 2'd1, 16'h0001, -1, 0, 0, -1, 1'b0);
        idle(1);
        // RAW10 WC=10, back to back and with 3-cycle gaps, on both VCs
        send_pkt(6'h2B, 2'd0, 16'd10, -1, 0, 0, -1, 1'b1);
        idle(2);
        send_pkt(6'h2B, 2'd1, 16'd10, -1, 3, 3, -1, 1'b1);
        idle(2);
        send_pkt(6'h2B, 2'd0, 16'd10, -1, 3, 3, -1, 1'b1);
        // Flipped WC bit, line start short packet, WC=0 long packet
        send_pkt(6'h2B, 2'd1, 16'd10, 12, 0, 0, -1, 1'b1);
        idle(1);
        send_pkt(6'h02, 2'd1, 16'd5, -1, 0, 0, -1, 1'b0);
        send_pkt(6'h2B, 2'd1, 16'd0, -1, 0, 1, -1, 1'b0);
        idle(1);
        // Truncation after 2 of 5 words, then truncation by a corrupted header
        send_pkt(6'h2B, 2'd1, 16'd18, -1, 0, 0, 2, 1'b1);
        send_pkt(6'h00, 2'd1, 16'd0, -1, 0, 0, -1, 1'b0);
        send_pkt(6'h2B, 2'd1, 16'd18, -1, 0, 0, 1, 1'b1);
        send_pkt(6'h2C, 2'd1, 16'd4, 3, 0, 0, -1, 1'b0);
        idle(2);
        // Mid-packet reset
        send_pkt(6'h2B, 2'd1, 16'd18, -1, 0, 0, 2, 1'b1);
        do_reset();
        idle(2);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            logic [5:0] dt;
            logic [15:0] wc;
            dt = ($urandom_range(0, 3) == 0) ? 6'($urandom) : dt_pick[$urandom_range(0, 5)];
            wc = (dt >= 6'h10) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            send_pkt(dt, 2'($urandom), wc,
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -1,
                     0, 2,
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
                     1'($urandom));
            idle($urandom_range(0, 2));
        end

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            send_pkt(6'h12, 2'($urandom), 16'($urandom), int'($urandom_range(0, 31)),
                     0, 0, 0, 1'b0);
        end
        send_pkt(6'h2B, 2'd1, 16'd18, -1, 0, 0, 1, 1'b1);
        send_pkt(6'h2C, 2'd1, 16'd4, 5, 0, 0, -1, 1'b0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
